// File: rtl/v35_intc.sv
// v35_intc: NUM_CH-channel maskable interrupt controller. Each channel has its own
// priority, trigger mode and polarity. ISPR tracks nesting, and requests go to the core over an ack/fini handshake.
module v35_intc #(
  parameter int NUM_CH   = 8,
  parameter int VEC_BASE = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_cycle,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [5:0]        reg_addr,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  output logic              irq_req,
  output logic [7:0]        irq_vec,
  input  logic              irq_ack,
  input  logic              irq_fini
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] if_q, if_d, mk_q, mk_d, lvl_q, lvl_d, prev_q, prev_d;
  logic [2:0]        pr_q [NUM_CH];
  logic [2:0]        pr_d [NUM_CH];
  logic [15:0]       pol_q, pol_d;
  logic [7:0]        ispr_q, ispr_d, vec_q, vec_d, dout_q, dout_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic              req_q, req_d;

  logic [NUM_CH-1:0] active, hw_set, elig;
  logic              ispr_any;
  logic [2:0]        ispr_lo;
  logic              win_any;
  logic [CW-1:0]     win_ch;
  logic [2:0]        win_pr;

  always_comb begin
    ispr_any = |ispr_q;
    ispr_lo  = '0;
    for (int unsigned i = 8; i > 0; i--)
      if (ispr_q[i-1]) ispr_lo = 3'(i-1);
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      active[k] = (irq_in[k] == pol_q[k]);
      hw_set[k] = ce_cycle && active[k] && (lvl_q[k] || (irq_in[k] != prev_q[k]));
      elig[k]   = if_q[k] && !mk_q[k] && (!ispr_any || (pr_q[k] < ispr_lo));
    end
  end

  // Strict '<' while scanning upward keeps the lowest channel on a priority tie.
  always_comb begin
    win_any = 1'b0;
    win_ch  = '0;
    win_pr  = '1;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (elig[k] && (!win_any || (pr_q[k] < win_pr))) begin
        win_any = 1'b1;
        win_ch  = CW'(k);
        win_pr  = pr_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if_d    = if_q;
    mk_d    = mk_q;
    lvl_d   = lvl_q;
    pr_d    = pr_q;
    pol_d   = pol_q;
    ispr_d  = ispr_q;
    prev_d  = prev_q;
    ch_d    = ch_q;
    req_d   = req_q;
    vec_d   = vec_q;
    dout_d  = dout_q;

    if (reg_rd) begin
      dout_d = '0;
      for (int unsigned k = 0; k < NUM_CH; k++)
        if (reg_addr == 6'(k)) dout_d = {if_q[k], mk_q[k], lvl_q[k], 2'b00, pr_q[k]};
      case (reg_addr)
        6'h20:   dout_d = pol_q[7:0];
        6'h21:   dout_d = pol_q[15:8];
        6'h30:   dout_d = ispr_q;
        default: ;
      endcase
    end

    if (reg_wr) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (reg_addr == 6'(k)) begin
          if_d[k]  = reg_din[7];
          mk_d[k]  = reg_din[6];
          lvl_d[k] = reg_din[5];
          pr_d[k]  = reg_din[2:0];
        end
      end
      case (reg_addr)
        6'h20:   pol_d[7:0]  = reg_din;
        6'h21:   pol_d[15:8] = reg_din;
        6'h30:   ispr_d      = reg_din;
        default: ;
      endcase
    end

    // An active level source pins IF high against software clears.
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (lvl_q[k] && active[k] && if_q[k]) if_d[k] = 1'b1;

    if (ce_cycle) begin
      prev_d = irq_in;
      if (irq_fini && ispr_any) ispr_d[ispr_lo] = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_any) begin
            ch_d    = win_ch;
            vec_d   = 8'(VEC_BASE) + 8'(win_ch);
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            ispr_d[pr_q[ch_q]] = 1'b1;
            if (!lvl_q[ch_q]) if_d[ch_q] = 1'b0;
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else if (!elig[ch_q]) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Hardware set is applied last so it wins over write and ack clears.
    if_d = if_d | hw_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      if_q    <= '0;
      mk_q    <= '1;
      lvl_q   <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) pr_q[k] <= 3'd7;
      pol_q   <= '0;
      ispr_q  <= '0;
      prev_q  <= '0;
      ch_q    <= '0;
      req_q   <= 1'b0;
      vec_q   <= 8'(VEC_BASE);
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      mk_q    <= mk_d;
      lvl_q   <= lvl_d;
      pr_q    <= pr_d;
      pol_q   <= pol_d;
      ispr_q  <= ispr_d;
      prev_q  <= prev_d;
      ch_q    <= ch_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      dout_q  <= dout_d;
    end
  end

  assign irq_req  = req_q;
  assign irq_vec  = vec_q;
  assign reg_dout = dout_q;

endmodule

// File: tb/tb_v35_intc.sv
// Self-checking bench for v35_intc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_v35_intc;
  localparam int NCH = 8;
  localparam int VB  = 24;

  logic       clk, reset, ce_cycle;
  logic [7:0] irq_in;
  logic       reg_wr, reg_rd;
  logic [5:0] reg_addr;
  logic [7:0] reg_din, reg_dout;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic       irq_ack, irq_fini;

  int n_checks = 0;
  int n_fail   = 0;

  v35_intc #(.NUM_CH(NCH), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .ce_cycle(ce_cycle), .irq_in(irq_in),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_din(reg_din),
    .reg_dout(reg_dout), .irq_req(irq_req), .irq_vec(irq_vec),
    .irq_ack(irq_ack), .irq_fini(irq_fini)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_if[16], m_mk[16], m_lvl[16], m_pr[16];
  int m_pol, m_ispr, m_prev, m_ch, m_vec, m_dout;
  bit m_pend;

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_if[k] = 0; m_mk[k] = 1; m_lvl[k] = 0; m_pr[k] = 7;
    end
    m_pol = 0; m_ispr = 0; m_prev = 0; m_pend = 0; m_ch = 0; m_vec = VB; m_dout = 0;
  endtask

  function automatic bit m_elig(int k);
    int low = m_ispr & -m_ispr;
    return (m_if[k] != 0) && (m_mk[k] == 0) && (m_ispr == 0 || (1 << m_pr[k]) < low);
  endfunction

  task automatic model_step();
    int n_if[16], n_mk[16], n_lvl[16], n_pr[16];
    int n_pol, n_ispr, n_prev, n_ch, n_vec, n_dout;
    bit n_pend;
    int a, d, inv, best;
    n_if = m_if; n_mk = m_mk; n_lvl = m_lvl; n_pr = m_pr;
    n_pol = m_pol; n_ispr = m_ispr; n_prev = m_prev; n_ch = m_ch; n_vec = m_vec;
    n_dout = m_dout; n_pend = m_pend;
    a = int'(reg_addr); d = int'(reg_din); inv = int'(irq_in);
    if (reg_rd) begin
      if (a < NCH) n_dout = m_if[a] * 128 + m_mk[a] * 64 + m_lvl[a] * 32 + m_pr[a];
      else if (a == 'h20) n_dout = m_pol & 255;
      else if (a == 'h21) n_dout = (m_pol >> 8) & 255;
      else if (a == 'h30) n_dout = m_ispr;
      else n_dout = 0;
    end
    if (reg_wr) begin
      if (a < NCH) begin
        n_if[a] = (d >> 7) & 1; n_mk[a] = (d >> 6) & 1; n_lvl[a] = (d >> 5) & 1; n_pr[a] = d & 7;
      end else if (a == 'h20) n_pol = (m_pol & 'hFF00) | d;
      else if (a == 'h21) n_pol = (m_pol & 'h00FF) | (d << 8);
      else if (a == 'h30) n_ispr = d;
    end
    for (int k = 0; k < NCH; k++)
      if (m_lvl[k] != 0 && ((inv >> k) & 1) == ((m_pol >> k) & 1) && m_if[k] != 0) n_if[k] = 1;
    if (ce_cycle) begin
      n_prev = inv;
      if (irq_fini && m_ispr != 0) n_ispr = n_ispr & ~(m_ispr & -m_ispr);
      if (m_pend) begin
        if (irq_ack) begin
          n_ispr = n_ispr | (1 << m_pr[m_ch]);
          if (m_lvl[m_ch] == 0) n_if[m_ch] = 0;
          n_pend = 0;
        end else if (!m_elig(m_ch)) n_pend = 0;
      end else begin
        best = -1;
        for (int k = 0; k < NCH; k++)
          if (m_elig(k) && (best < 0 || m_pr[k] * 16 + k < m_pr[best] * 16 + best)) best = k;
        if (best >= 0) begin
          n_pend = 1; n_ch = best; n_vec = (VB + best) % 256;
        end
      end
      for (int k = 0; k < NCH; k++)
        if (((inv >> k) & 1) == ((m_pol >> k) & 1) &&
            (m_lvl[k] != 0 || ((inv >> k) & 1) != ((m_prev >> k) & 1))) n_if[k] = 1;
    end
    m_if = n_if; m_mk = n_mk; m_lvl = n_lvl; m_pr = n_pr;
    m_pol = n_pol; m_ispr = n_ispr; m_prev = n_prev; m_ch = n_ch; m_vec = n_vec;
    m_dout = n_dout; m_pend = n_pend;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("irq_req", int'(irq_req), int'(m_pend));
      check("irq_vec", int'(irq_vec), m_vec);
      check("reg_dout", int'(reg_dout), m_dout);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [5:0] a, input int exp);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    check(nm, int'(reg_dout), exp);
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_fini();
    irq_fini = 1'b1; tick(); irq_fini = 1'b0;
  endtask

  task automatic wait_req(input string nm, input int exp_vec);
    int n = 0;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_req"}, int'(irq_req), 1);
    check({nm, "_vec"}, int'(irq_vec), exp_vec);
  endtask

  task automatic idle_chk(input string nm, input int cycles);
    repeat (cycles) tick();
    check(nm, int'(irq_req), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [5:0] addrs [12];

  initial begin
    logic [7:0] din;
    int idx;
    addrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
              6'h20, 6'h21, 6'h30, 6'h3F};
    reset = 1'b0; ce_cycle = 1'b1; irq_in = '0; reg_wr = 1'b0; reg_rd = 1'b0;
    reg_addr = '0; reg_din = '0; irq_ack = 1'b0; irq_fini = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_req", int'(irq_req), 0);
    check("rst_vec", int'(irq_vec), 24);
    check("rst_dout", int'(reg_dout), 0);
    rd_chk("rst_ic0", 6'h00, 'h47);
    rd_chk("rst_ispr", 6'h30, 0);

    // 1: single edge channel
    wr(6'h02, 8'h03);
    wr(6'h20, 8'h04);
    irq_in[2] = 1'b1;
    wait_req("t1", 26);
    pulse_ack();
    check("t1_ackdrop", int'(irq_req), 0);
    rd_chk("t1_ispr", 6'h30, 'h08);
    rd_chk("t1_ic2", 6'h02, 'h03);
    irq_in[2] = 1'b0;
    pulse_fini();
    rd_chk("t1_ispr_fini", 6'h30, 0);

    // 2: priority and tie-break
    wr(6'h20, 8'hFF);
    wr(6'h00, 8'h05);
    wr(6'h05, 8'h01);
    irq_in[0] = 1'b1; irq_in[5] = 1'b1;
    wait_req("t2a", 29);
    pulse_ack();
    rd_chk("t2_ispr", 6'h30, 'h02);
    idle_chk("t2_block", 2);
    pulse_fini();
    wait_req("t2b", 24);
    pulse_ack(); pulse_fini();
    irq_in[0] = 1'b0; irq_in[5] = 1'b0;
    wr(6'h03, 8'h04);
    wr(6'h06, 8'h04);
    irq_in[3] = 1'b1; irq_in[6] = 1'b1;
    wait_req("t2tie", 27);
    pulse_ack(); pulse_fini();
    wait_req("t2tie2", 30);
    pulse_ack(); pulse_fini();
    irq_in[3] = 1'b0; irq_in[6] = 1'b0;

    // 3: nesting
    wr(6'h01, 8'h03);
    wr(6'h04, 8'h03);
    wr(6'h06, 8'h01);
    irq_in[1] = 1'b1;
    wait_req("t3a", 25);
    pulse_ack();
    rd_chk("t3_ispr1", 6'h30, 'h08);
    irq_in[4] = 1'b1; irq_in[6] = 1'b1;
    wait_req("t3b", 30);
    pulse_ack();
    rd_chk("t3_ispr2", 6'h30, 'h0A);
    idle_chk("t3_block", 1);
    pulse_fini();
    rd_chk("t3_ispr3", 6'h30, 'h08);
    pulse_fini();
    wait_req("t3c", 28);
    pulse_ack(); pulse_fini();
    irq_in[1] = 1'b0; irq_in[4] = 1'b0; irq_in[6] = 1'b0;

    // 4: level mode
    wr(6'h03, 8'h22);
    irq_in[3] = 1'b1;
    wait_req("t4a", 27);
    pulse_ack();
    rd_chk("t4_if_held", 6'h03, 'hA2);
    wr(6'h03, 8'h22);
    rd_chk("t4_swclr_blk", 6'h03, 'hA2);
    idle_chk("t4_block", 2);
    pulse_fini();
    wait_req("t4b", 27);
    irq_in[3] = 1'b0;
    tick();
    wr(6'h03, 8'h22);
    rd_chk("t4_swclr", 6'h03, 'h22);
    check("t4_withdraw", int'(irq_req), 0);
    wr(6'h03, 8'h62);

    // 5: withdraw by mask
    wr(6'h07, 8'h00);
    irq_in[7] = 1'b1;
    wait_req("t5a", 31);
    wr(6'h07, 8'hC0);
    rd_chk("t5_ispr", 6'h30, 0);
    check("t5_withdraw", int'(irq_req), 0);
    rd_chk("t5_ic7", 6'h07, 'hC0);

    // 6: reset during request
    wr(6'h07, 8'h80);
    wait_req("t6a", 31);
    #2 reset = 1'b1;
    #1;
    check("t6_req_async", int'(irq_req), 0);
    check("t6_vec_async", int'(irq_vec), 24);
    @(negedge clk);
    reset = 1'b0;
    irq_in = '0;
    for (int k = 0; k < NCH; k++) rd_chk("t6_ic", 6'(k), 'h47);
    rd_chk("t6_ispr", 6'h30, 0);
    rd_chk("t6_pol", 6'h20, 0);

    // random traffic against the model
    for (int k = 0; k < NCH; k++) begin
      din = 8'($urandom);
      if ($urandom % 4 != 0) din[6] = 1'b0;
      wr(6'(k), din);
    end
    wr(6'h20, 8'($urandom));
    for (int i = 0; i < 3000; i++) begin
      ce_cycle = ($urandom % 4) != 0;
      if ($urandom % 6 == 0) begin
        idx = int'($urandom % NCH);
        irq_in[idx] = ~irq_in[idx];
      end
      irq_ack  = (irq_req && ($urandom % 3 == 0)) || ($urandom % 16 == 0);
      irq_fini = ($urandom % 6) == 0;
      reg_wr   = ($urandom % 10) == 0;
      reg_rd   = ($urandom % 3) == 0;
      reg_addr = addrs[$urandom % 12];
      reg_din  = 8'($urandom);
      if (reg_wr && reg_addr < 6'h08 && ($urandom % 3 != 0)) reg_din[6] = 1'b0;
      @(negedge clk);
    end
    ce_cycle = 1'b1; irq_ack = 1'b0; irq_fini = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
